memory_loader: RTL

MEMORY_LOADER -- requirements
Module: memory_loader

---
 rtl/memory_loader.sv | 96 +++++++++
 1 files changed

// File: rtl/memory_loader.sv
// Byte-stream loader: packs 16 accepted bytes into a 128-bit word, writes it to
// memory in one cycle, and services single-cycle read-back requests between words.
module memory_loader #(
  parameter int FIRST_LSB = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  input  logic         rd_req,
  output logic [127:0] mem_in,
  output logic         mem_en,
  output logic         mem_mode,
  output logic [4:0]   fill_count,
  output logic         wr_done,
  output logic         rd_valid
);

  typedef enum logic [1:0] {FILL, WRITE, RD_ISSUE, RD_WAIT} state_e;

  state_e         state_q, state_d;
  logic [127:0]   buf_q, buf_d;
  logic [4:0]     cnt_q, cnt_d;
  logic           wr_done_q, wr_done_d;
  logic [3:0]     lane;

  assign lane = (FIRST_LSB != 0) ? cnt_q[3:0] : (4'd15 - cnt_q[3:0]);

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    wr_done_d  = 1'b0;
    byte_ready = 1'b0;
    mem_en     = 1'b0;
    mem_mode   = 1'b0;
    rd_valid   = 1'b0;
    case (state_q)
      FILL: begin
        // A read is only taken between words; it wins over a simultaneous byte.
        if (cnt_q == 5'd0 && rd_req) begin
          state_d = RD_ISSUE;
        end else begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            buf_d[{lane, 3'b000} +: 8] = byte_in;
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd15) state_d = WRITE;
          end
        end
      end
      WRITE: begin
        mem_en    = 1'b1;
        mem_mode  = 1'b1;
        buf_d     = '0;
        cnt_d     = '0;
        wr_done_d = 1'b1;
        state_d   = FILL;
      end
      RD_ISSUE: begin
        mem_en  = 1'b1;
        state_d = RD_WAIT;
      end
      RD_WAIT: begin
        rd_valid = 1'b1;
        state_d  = FILL;
      end
      default: state_d = FILL;
    endcase
    if (rst) begin
      byte_ready = 1'b0;
      mem_en     = 1'b0;
      mem_mode   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FILL;
      buf_q     <= '0;
      cnt_q     <= '0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      cnt_q     <= cnt_d;
      wr_done_q <= wr_done_d;
    end
  end

  assign mem_in     = buf_q;
  assign fill_count = cnt_q;
  assign wr_done    = wr_done_q;

endmodule
